// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Latency: none (wires only).
// Backpressure: request held by master until IMemReady; one response per accepted request.
//   master (fetch): drives IMemReqF/IMemAddrF, receives IMemReady/IMemRValid/IMemRData.
//   slave  (imem) : the mirror image.
interface fetch_unit_if;
  logic        IMemReqF;
  logic [31:0] IMemAddrF;
  logic        IMemReady;
  logic        IMemRValid;
  logic [31:0] IMemRData;

  modport master (
    output IMemReqF, IMemAddrF,
    input  IMemReady, IMemRValid, IMemRData
  );

  modport slave (
    input  IMemReqF, IMemAddrF,
    output IMemReady, IMemRValid, IMemRData
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch with single-outstanding imem requests, one-entry skid and IF/ID register.
// Latency: accept in n, response in n+k -> InstrD valid in n+k+1; 1 instr/cycle when k=1.
// Backpressure: StallD parks one word in the skid and stops issue; StallF/PCWrPendingF block issue.
//   clk, reset (async active-low); StallF/StallD/FlushD from hazard unit; PCWrPendingF from controller;
//   BranchTakenE/ALUResultE and PCSrcW/ResultW redirect; imem bus via fetch_unit_if.master;
//   InstrD/PCPlus8D/ValidD form the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE180_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                StallF,
  input  logic                StallD,
  input  logic                FlushD,
  input  logic                PCWrPendingF,
  input  logic                BranchTakenE,
  input  logic [31:0]         ALUResultE,
  input  logic                PCSrcW,
  input  logic [31:0]         ResultW,
  fetch_unit_if.master        imem,
  output logic [31:0]         InstrD,
  output logic [31:0]         PCPlus8D,
  output logic                ValidD
);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t      state, stateNext;
  logic [31:0] PCF, PCReq;
  logic        skidValid;
  logic [31:0] skidData, skidPC;

  logic        redirect;
  logic [31:0] target;
  logic        respIn;     // response arriving for the outstanding request
  logic        consume;    // response kept (not killed by a redirect)
  logic        dAdvance;
  logic        skidFill;
  logic        issue;
  logic        accept;

  always_comb begin
    redirect  = PCSrcW | BranchTakenE;
    target    = PCSrcW ? ResultW : ALUResultE;  // W-stage write is older, so it wins
    respIn    = (state == WAIT) & imem.IMemRValid;
    consume   = respIn & ~redirect;
    dAdvance  = ~StallD;
    // A kept word goes to D only if D moves and nothing older sits in the skid.
    skidFill  = consume & ~(dAdvance & ~skidValid);
    // Issue also waits while the skid is being filled: otherwise a back-to-back
    // response could arrive with the skid full and D still stalled, and be lost.
    issue     = reset & ((state == IDLE) | respIn) & ~StallF & ~PCWrPendingF
              & ~redirect & ~skidValid & ~skidFill;
    accept    = issue & imem.IMemReady;
  end

  assign imem.IMemReqF  = issue;
  assign imem.IMemAddrF = PCF;

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // FSM: next state
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) stateNext = WAIT;
      end
      WAIT: begin
        if (imem.IMemRValid) stateNext = accept ? WAIT : IDLE;
        else if (redirect)   stateNext = DISCARD;
      end
      DISCARD: begin
        // Stale response still owed; a redirect here only moves PCF.
        if (imem.IMemRValid) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // PC, skid buffer and IF/ID register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PCF       <= RESET_PC;
      PCReq     <= RESET_PC;
      skidValid <= 1'b0;
      skidData  <= 32'h0;
      skidPC    <= 32'h0;
      InstrD    <= NOP_INSTR;
      PCPlus8D  <= 32'h0;
      ValidD    <= 1'b0;
    end else begin
      if (redirect)    PCF <= target;
      else if (accept) PCF <= PCF + 32'd4;

      if (accept) PCReq <= PCF;

      if (redirect) begin
        skidValid <= 1'b0;
      end else if (skidFill) begin
        skidValid <= 1'b1;
        skidData  <= imem.IMemRData;
        skidPC    <= PCReq;
      end else if (dAdvance) begin
        skidValid <= 1'b0;
      end

      if (FlushD) begin
        ValidD <= 1'b0;
        InstrD <= NOP_INSTR;
      end else if (dAdvance) begin
        if (skidValid) begin
          ValidD   <= 1'b1;
          InstrD   <= skidData;
          PCPlus8D <= skidPC + 32'd8;
        end else if (consume) begin
          ValidD   <= 1'b1;
          InstrD   <= imem.IMemRData;
          PCPlus8D <= PCReq + 32'd8;
        end else begin
          ValidD <= 1'b0;
          InstrD <= NOP_INSTR;
        end
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the pipeline controller and decode stage. It owns the fetch PC and issues single-outstanding requests to a variable-latency instruction memory. It buffers returned words through a one-entry skid buffer and presents `InstrD`/`PCPlus8D` to decode. Redirects come from `BranchTakenE` (E-stage branch) and `PCSrcW` (W-stage PC write); fetch issue holds while `PCWrPendingF` is high.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch PC after reset.
- `NOP_INSTR`, 32'hE180_0000 (ORR R0,R0,R0): bubble encoding driven on `InstrD` when `ValidD`=0.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; state cleared immediately while low.
- `StallF` in 1, `StallD` in 1, `FlushD` in 1: from the hazard unit.
- `PCWrPendingF` in 1: from the controller; blocks new issue.
- `BranchTakenE` in 1, `ALUResultE` in 32: E-stage redirect and target.
- `PCSrcW` in 1, `ResultW` in 32: W-stage redirect and target.
- `IMemReqF` out 1: request valid.
- `IMemAddrF` out 32: request address (= PCF).
- `IMemReady` in 1: memory accepts the request this cycle.
- `IMemRValid` in 1, `IMemRData` in 32: read response.
- `InstrD` out 32, `PCPlus8D` out 32, `ValidD` out 1: IF/ID register.

## Operation
- State: `PCF`, `PCReq` (address of outstanding request), FSM {IDLE, WAIT, DISCARD}, skid {valid, data, pc}, D register.
- Redirect = `PCSrcW | BranchTakenE`. Target = `ResultW` if `PCSrcW`, else `ALUResultE`; W wins on simultaneous assertion.
- Issue condition: `IMemReqF` = state∈{IDLE, or WAIT with `IMemRValid` this cycle} & !`StallF` & !`PCWrPendingF` & !redirect & skid empty.
- Accept (`IMemReqF & IMemReady`): `PCReq`<=`PCF`, `PCF`<=`PCF`+4 (mod 2^32), next state WAIT.
- WAIT & `IMemRValid`: response consumed. Next state is WAIT if a new request is accepted in the same cycle, else IDLE.
- Consumed response destination: the D register if it advances this cycle and skid is empty; else the skid buffer.
- `IMemRValid` in IDLE: ignored.
- `IMemAddrF` holds stable while `IMemReqF`=1 and !`IMemReady`. The request may be withdrawn only by redirect, `StallF` or `PCWrPendingF`.
- D advance when !`StallD`, loading in priority order: skid content; then consumed response; else bubble (`ValidD`<=0, `InstrD`<=`NOP_INSTR`).
- `PCPlus8D` <= source PC + 8, wrapping mod 2^32.
- `StallD`=1: D register holds.
- `FlushD`=1: D loads bubble regardless of `StallD`. Skid and FSM are unaffected.
- Redirect cycle: `PCF`<=target, skid cleared, no issue.
  - WAIT without `IMemRValid` → DISCARD.
  - WAIT with `IMemRValid` → response dropped, IDLE.
  - IDLE stays IDLE.
- DISCARD: the next `IMemRValid` is dropped, then → IDLE. No issue in DISCARD. A redirect in DISCARD updates `PCF` and stays DISCARD.

## Timing
- Reset values: `PCF`=`RESET_PC`, FSM=IDLE, skid empty.
- Outputs in reset: `IMemReqF`=0, `IMemAddrF`=`RESET_PC`, `ValidD`=0, `InstrD`=`NOP_INSTR`, `PCPlus8D`=0.
- First request: first cycle after `reset` deasserts.
- Latency: request accepted in cycle n, `IMemRValid` in n+k (k≥1) → `InstrD` valid in cycle n+k+1.
- Throughput: 1 instruction/cycle when k=1, `IMemReady`=1 and no stalls.
- Redirect asserted in cycle n: request at target earliest in cycle n+1 (IDLE), or one cycle after the discarded response (DISCARD).
- Skid never holds more than one entry: issue is suppressed while it is full.
- `reset` low mid-WAIT: outstanding request abandoned; a response after reset release is ignored (IDLE).

## Test plan
- Reset release, `IMemReady`=1, k=1, words A,B,C: addresses 0,4,8 on consecutive cycles; `InstrD`=A,B,C with `PCPlus8D`=8,12,16 and `ValidD`=1.
- `StallD` high 3 cycles while responses return: one word captured in skid, issue stops, no word lost or duplicated; order preserved after release.
- `BranchTakenE`=1, `ALUResultE`=0x100 while WAIT with k=3: the stale response is dropped (DISCARD); next request address 0x100; `InstrD` never shows the stale word.
- `PCSrcW`=1 (`ResultW`=0x200) and `BranchTakenE`=1 (`ALUResultE`=0x100) in the same cycle: next address 0x200.
- `PCWrPendingF` high 4 cycles: `IMemReqF`=0 throughout; `FlushD` yields `ValidD`=0, `InstrD`=0xE180_0000.
- `PCF`=0xFFFF_FFFC fetch: `PCPlus8D`=0x0000_0004, next address 0x0000_0000. `reset` pulsed low mid-WAIT: outputs return to reset values immediately.
